// File: rtl/hazard_display_stepper.sv
// hazard_display_stepper: snapshots instruction/hazard vectors and steps through them on debounced presses
module hazard_display_stepper #(
  parameter int NUM_INSTR = 8,
  parameter int INSTR_W = 8,
  parameter int DEBOUNCE_CYCLES = 16
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_INSTR*INSTR_W-1:0] instrMemBits,
  input  logic [NUM_INSTR*INSTR_W-1:0] hazardMemBits,
  input  logic                         load,
  input  logic                         but_next,
  output logic [INSTR_W-1:0]           led_instr,
  output logic [INSTR_W-1:0]           led_hazard,
  output logic [2:0]                   idx,
  output logic                         hazard_any,
  output logic [6:0]                   hazard_total,
  output logic                         done
);
  localparam int NW = NUM_INSTR * INSTR_W;
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [2:0] LAST = 3'(NUM_INSTR - 1);
  typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;
  state_t state, state_n;
  logic [NW-1:0] snap_i, snap_h, snap_i_n, snap_h_n;
  logic [2:0] idx_n;
  logic [INSTR_W-1:0] led_instr_n, led_hazard_n;
  logic [6:0] total_n, pop;
  logic s1, s2, stable, step, flip;
  logic [CW-1:0] cnt;
  assign flip = (s2 != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {s1, s2, stable, step} <= '0;
      cnt <= '0;
    end else begin
      s1 <= but_next;
      s2 <= s1;
      cnt <= (s2 == stable || flip) ? '0 : cnt + 1'b1;
      stable <= stable ^ flip;
      step <= flip & ~stable;
    end
  always_comb begin
    pop = '0;
    for (int i = 0; i < NW; i++) pop = pop + 7'(hazardMemBits[i]);
  end
  // load has priority; step only matters in SHOW/DONE
  always_comb begin
    state_n = state;
    idx_n = idx;
    snap_i_n = snap_i;
    snap_h_n = snap_h;
    if (load) begin
      state_n = SHOW;
      idx_n = '0;
      snap_i_n = instrMemBits;
      snap_h_n = hazardMemBits;
    end else if (step && state == SHOW) begin
      state_n = idx == LAST ? DONE : SHOW;
      idx_n = idx == LAST ? idx : idx + 3'd1;
    end else if (step && state == DONE) begin
      state_n = IDLE;
      idx_n = '0;
    end
    led_instr_n = state_n == IDLE ? '0 : snap_i_n[idx_n*INSTR_W +: INSTR_W];
    led_hazard_n = state_n == IDLE ? '0 : snap_h_n[idx_n*INSTR_W +: INSTR_W];
    total_n = load ? pop : state_n == IDLE ? '0 : hazard_total;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      snap_i <= '0;
      snap_h <= '0;
      led_instr <= '0;
      led_hazard <= '0;
      hazard_total <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      snap_i <= snap_i_n;
      snap_h <= snap_h_n;
      led_instr <= led_instr_n;
      led_hazard <= led_hazard_n;
      hazard_total <= total_n;
    end
  assign hazard_any = |led_hazard;
  assign done = state == DONE;
endmodule
